// File: rtl/hamming_secded_dec_pipe_if.sv
// Streaming bus for hamming_secded_dec_pipe: received codeword in, decoded word out.
interface hamming_secded_dec_pipe_if #(
   parameter int DATA_W = 4
);
   function automatic int par_width(input int dw);
      int p;
      p = 1;
      while ((1 << p) < dw + p + 1) p = p + 1;
      return p;
   endfunction

   localparam int PAR_W = par_width(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;

   logic              in_valid;
   logic              in_ready;
   logic [CW_W-1:0]   in_codeword;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_single_err;
   logic              out_double_err;
   logic [PAR_W-1:0]  out_syndrome;

   modport slave (
      input  in_valid, in_codeword, out_ready,
      output in_ready, out_valid, out_data, out_single_err, out_double_err, out_syndrome
   );

   modport master (
      output in_valid, in_codeword, out_ready,
      input  in_ready, out_valid, out_data, out_single_err, out_double_err, out_syndrome
   );
endinterface

// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready
// streaming and saturating error-statistics counters.
module hamming_secded_dec_pipe #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   hamming_secded_dec_pipe_if.slave    bus,
   input  logic                        cnt_clr,
   output logic [CNT_W-1:0]            cnt_corrected,
   output logic [CNT_W-1:0]            cnt_uncorrectable
);
   function automatic int par_width(input int dw);
      int p;
      p = 1;
      while ((1 << p) < dw + p + 1) p = p + 1;
      return p;
   endfunction

   localparam int PAR_W = par_width(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;

   // XOR of the indices of all set Hamming positions (bit 0 excluded).
   function automatic logic [PAR_W-1:0] calc_syn(input logic [CW_W-1:0] cw);
      logic [PAR_W-1:0] s;
      s = '0;
      for (int unsigned i = 1; i < CW_W; i++) begin
         if (cw[i]) s = s ^ PAR_W'(i);
      end
      return s;
   endfunction

   // Gather data bits from the non-power-of-two positions, lowest first.
   function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
      logic [DATA_W-1:0] d;
      int unsigned       k;
      d = '0;
      k = 0;
      for (int unsigned i = 1; i < CW_W; i++) begin
         if ((i & (i - 1)) != 0) begin
            d[k] = cw[i];
            k    = k + 1;
         end
      end
      return d;
   endfunction

   logic              rdy_q;
   logic              s2_adv, s1_adv, accept;

   logic              s1_valid_q, s1_valid_d;
   logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
   logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;

   logic              s2_valid_q;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic              s2_sgl_q, s2_sgl_d;
   logic              s2_dbl_q, s2_dbl_d;
   logic [PAR_W-1:0]  s2_syn_q;
   logic [CW_W-1:0]   fixed_cw;

   logic [CNT_W-1:0]  cor_q, unc_q;

   assign s2_adv       = !s2_valid_q || bus.out_ready;
   assign s1_adv       = !s1_valid_q || s2_adv;
   assign bus.in_ready = rdy_q && s1_adv;
   assign accept       = bus.in_valid && bus.in_ready;

   // Input acceptance is held off until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   // Stage 1 next state: capture codeword, syndrome and overall parity.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_cw_d    = s1_cw_q;
      s1_syn_d   = s1_syn_q;
      s1_par_d   = s1_par_q;
      if (s1_adv) s1_valid_d = accept;
      if (accept) begin
         s1_cw_d  = bus.in_codeword;
         s1_syn_d = calc_syn(bus.in_codeword);
         s1_par_d = ^bus.in_codeword;
      end
   end

   // Stage 1 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s1_syn_q   <= '0;
         s1_par_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_cw_q    <= s1_cw_d;
         s1_syn_q   <= s1_syn_d;
         s1_par_q   <= s1_par_d;
      end
   end

   // Stage 2 classification and single-bit correction.
   always_comb begin
      fixed_cw = s1_cw_q;
      s2_sgl_d = 1'b0;
      s2_dbl_d = 1'b0;
      if (s1_syn_q == '0) begin
         s2_sgl_d = s1_par_q;
      end else if (s1_par_q && (int'(s1_syn_q) <= CW_W - 1)) begin
         fixed_cw[s1_syn_q] = ~s1_cw_q[s1_syn_q];
         s2_sgl_d           = 1'b1;
      end else begin
         s2_dbl_d = 1'b1;
      end
      s2_data_d = extract(fixed_cw);
   end

   // Stage 2 registers; contents only change when the stage advances with a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_sgl_q   <= 1'b0;
         s2_dbl_q   <= 1'b0;
         s2_syn_q   <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= s2_data_d;
            s2_sgl_q  <= s2_sgl_d;
            s2_dbl_q  <= s2_dbl_d;
            s2_syn_q  <= s1_syn_q;
         end
      end
   end

   // Saturating statistics; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cor_q <= '0;
         unc_q <= '0;
      end else if (cnt_clr) begin
         cor_q <= '0;
         unc_q <= '0;
      end else if (s2_valid_q && bus.out_ready) begin
         if (s2_sgl_q && (cor_q != '1)) cor_q <= cor_q + CNT_W'(1);
         if (s2_dbl_q && (unc_q != '1)) unc_q <= unc_q + CNT_W'(1);
      end
   end

   assign bus.out_valid      = s2_valid_q;
   assign bus.out_data       = s2_data_q;
   assign bus.out_single_err = s2_sgl_q;
   assign bus.out_double_err = s2_dbl_q;
   assign bus.out_syndrome   = s2_syn_q;
   assign cnt_corrected      = cor_q;
   assign cnt_uncorrectable  = unc_q;
endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Directed bench for hamming_secded_dec_pipe (DATA_W=4, CNT_W=2).
module tb_hamming_secded_dec_pipe;
   localparam int DATA_W = 4;
   localparam int CNT_W  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cnt_clr = 1'b0;
   logic [CNT_W-1:0] cnt_corrected, cnt_uncorrectable;

   hamming_secded_dec_pipe_if #(.DATA_W(DATA_W)) bus ();

   hamming_secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus               (bus),
      .cnt_clr           (cnt_clr),
      .cnt_corrected     (cnt_corrected),
      .cnt_uncorrectable (cnt_uncorrectable)
   );

   always #5 clk = ~clk;

   // Hand-computed vectors: codeword, data, single, double, syndrome.
   logic [7:0] v_cw   [6] = '{8'hAA, 8'h8A, 8'h82, 8'hAB, 8'h2A, 8'hAE};
   logic [3:0] v_data [6] = '{4'b1011, 4'b1011, 4'b1000, 4'b1011, 4'b1011, 4'b1011};
   logic       v_sgl  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       v_dbl  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [2:0] v_syn  [6] = '{3'd0, 3'd5, 3'd6, 3'd0, 3'd7, 3'd2};

   int n_chk = 0;
   int n_err = 0;
   int q[$];
   int cur_idx = 0;
   bit chk_rdy = 1'b0;
   bit held_v = 1'b0;
   logic [3:0] h_data;
   logic       h_sgl, h_dbl;
   logic [2:0] h_syn;
   int m_cor = 0;
   int m_unc = 0;
   bit tog_en = 1'b0;
   int tog_k = 0;
   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: in-order results, hold stability, ready model, counter model.
   always @(negedge clk) begin
      int inflight;
      int idx;
      if (!rst_n) begin
         q.delete();
         held_v = 1'b0;
         m_cor  = 0;
         m_unc  = 0;
      end else begin
         inflight = q.size();
         check("cnt_corrected", 64'(cnt_corrected), 64'(m_cor));
         check("cnt_uncorrectable", 64'(cnt_uncorrectable), 64'(m_unc));
         if (chk_rdy) check("in_ready", 64'(bus.in_ready), 64'((inflight < 2) || bus.out_ready));
         if (held_v) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_data", 64'(bus.out_data), 64'(h_data));
            check("hold_flags", 64'({bus.out_single_err, bus.out_double_err}), 64'({h_sgl, h_dbl}));
            check("hold_syn", 64'(bus.out_syndrome), 64'(h_syn));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(bus.out_valid), 64'(0));
            end else begin
               idx = q.pop_front();
               check("out_data", 64'(bus.out_data), 64'(v_data[idx]));
               check("out_single_err", 64'(bus.out_single_err), 64'(v_sgl[idx]));
               check("out_double_err", 64'(bus.out_double_err), 64'(v_dbl[idx]));
               check("out_syndrome", 64'(bus.out_syndrome), 64'(v_syn[idx]));
               if (v_sgl[idx] && m_cor < 3) m_cor++;
               if (v_dbl[idx] && m_unc < 3) m_unc++;
            end
         end
         if (cnt_clr) begin
            m_cor = 0;
            m_unc = 0;
         end
         held_v = bus.out_valid && !bus.out_ready;
         h_data = bus.out_data;
         h_sgl  = bus.out_single_err;
         h_dbl  = bus.out_double_err;
         h_syn  = bus.out_syndrome;
         if (bus.in_valid && bus.in_ready) q.push_back(cur_idx);
      end
   end

   // Output backpressure pattern for the streaming section.
   always @(posedge clk) begin
      if (tog_en) begin
         #1 bus.out_ready = pat[tog_k % 6];
         tog_k++;
      end
   end

   task automatic send(input int idx);
      int t;
      cur_idx         = idx;
      bus.in_codeword = v_cw[idx];
      bus.in_valid    = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.in_ready && t < 100);
      if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q.size() != 0 || bus.out_valid) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 100) check("drain_timeout", 64'(q.size()), 64'(0));
   endtask

   task automatic pulse_clr();
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.in_valid    = 1'b0;
      bus.in_codeword = '0;
      bus.out_ready   = 1'b0;

      // Reset values.
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_out_data", 64'(bus.out_data), 64'(0));
      check("rst_flags", 64'({bus.out_single_err, bus.out_double_err}), 64'(0));
      check("rst_syndrome", 64'(bus.out_syndrome), 64'(0));
      check("rst_counters", 64'({cnt_corrected, cnt_uncorrectable}), 64'(0));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("ready_before_edge", 64'(bus.in_ready), 64'(0));
      @(posedge clk);
      #1 check("ready_after_edge", 64'(bus.in_ready), 64'(1));
      chk_rdy = 1'b1;
      bus.out_ready = 1'b1;

      // Single words, including first-word latency.
      send(0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("latency_1", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      check("latency_2", 64'(bus.out_valid), 64'(1));
      drain();
      check("clean_no_count", 64'(cnt_corrected), 64'(0));
      send(1); bus.in_valid = 1'b0; drain();
      check("cor_after_8A", 64'(cnt_corrected), 64'(1));
      send(2); bus.in_valid = 1'b0; drain();
      check("unc_after_82", 64'(cnt_uncorrectable), 64'(1));
      send(3); bus.in_valid = 1'b0; drain();
      check("cor_after_AB", 64'(cnt_corrected), 64'(2));
      pulse_clr();
      check("clr_cor", 64'(cnt_corrected), 64'(0));
      check("clr_unc", 64'(cnt_uncorrectable), 64'(0));
      send(4); send(5); bus.in_valid = 1'b0; drain();

      // Back-to-back stream under toggling backpressure.
      tog_en = 1'b1;
      send(0); send(1); send(2); send(3);
      bus.in_valid = 1'b0;
      drain();
      tog_en = 1'b0;
      @(posedge clk);
      #2 bus.out_ready = 1'b0;

      // Both stages full with out_ready low: input must be refused.
      send(0); send(1);
      cur_idx         = 2;
      bus.in_codeword = v_cw[2];
      bus.in_valid    = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("full_stall_ready", 64'(bus.in_ready), 64'(0));
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send(2);
      bus.in_valid = 1'b0;
      drain();

      // Saturation at 2^CNT_W-1.
      pulse_clr();
      for (int i = 0; i < 5; i++) begin
         send(1);
         bus.in_valid = 1'b0;
         drain();
      end
      check("cor_saturated", 64'(cnt_corrected), 64'(3));

      // Clear together with an accepted corrected word.
      bus.out_ready = 1'b0;
      send(1);
      bus.in_valid = 1'b0;
      t = 0;
      while (!bus.out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("clr_setup_valid", 64'(bus.out_valid), 64'(1));
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      cnt_clr       = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      check("clr_priority", 64'(cnt_corrected), 64'(0));
      check("clr_drained", 64'(bus.out_valid), 64'(0));

      // Reset in the middle of a stream.
      bus.out_ready = 1'b0;
      send(4); send(5);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      chk_rdy = 1'b0;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
      check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
      check("midrst_out_data", 64'(bus.out_data), 64'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 check("midrst_ready_back", 64'(bus.in_ready), 64'(1));
      chk_rdy = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("no_stale_output", 64'(bus.out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      send(3);
      bus.in_valid = 1'b0;
      drain();
      check("post_rst_cor", 64'(cnt_corrected), 64'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
